alu_issue_stage: RTL

//  Decode/issue stage that drives the ALU operand and opcode interface of the MIPS datapath.

---
 rtl/alu_issue_stage.sv | 284 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_issue_stage.sv
// -----------------------------------------------------------------------------
// alu_issue_stage
//
// Decode/issue stage feeding the ALU of the MIPS datapath. Decodes a 32-bit
// instruction together with the register-file read data into an ALU opcode,
// two operands and control bits, and registers the result into an ID/EX
// pipeline register with valid/ready flow control.
//
// ALU opcodes: 0 add, 1 sub, 2 and, 3 or, 4 sll, 5 srl, 6 slt.
//
// Optional feature macro: ALU_ISSUE_HAZARD_EN
//   defined   -> load-use interlock: an instruction that reads the register
//                being loaded by the lw currently held in EX is stalled, and
//                one bubble is inserted once EX consumes the lw.
//   undefined -> no interlock logic; software spaces load-use pairs.
//
// Parameters
//   DW  operand / register data width (must be at least 17)
//   RW  register index width
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   synchronous active-high reset
//   id_valid     in   id_* carry a valid instruction and operands
//   id_ready     out  stage accepts id_* this cycle (combinational)
//   id_instr     in   instruction word
//   id_rs_data   in   register-file value of rs
//   id_rt_data   in   register-file value of rt
//   flush        in   drop the EX entry and any input accepted this cycle
//   ex_ready     in   EX consumes ex_* this cycle
//   ex_valid     out  ex_* hold a valid issued operation
//   ex_aluop     out  ALU opcode
//   ex_in1       out  ALU operand 1
//   ex_in2       out  ALU operand 2
//   ex_rt_data   out  rt value carried forward (store data)
//   ex_rd        out  destination register (0 = no write)
//   ex_regwrite  out  result is written back
//   ex_memread   out  lw
//   ex_memwrite  out  sw
//   ex_branch    out  beq, EX uses the ALU zero flag
//   ex_illegal   out  undecodable instruction, all other controls 0
// -----------------------------------------------------------------------------
module alu_issue_stage #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          id_valid,
    output logic          id_ready,
    input  logic [31:0]   id_instr,
    input  logic [DW-1:0] id_rs_data,
    input  logic [DW-1:0] id_rt_data,
    input  logic          flush,
    input  logic          ex_ready,
    output logic          ex_valid,
    output logic [2:0]    ex_aluop,
    output logic [DW-1:0] ex_in1,
    output logic [DW-1:0] ex_in2,
    output logic [DW-1:0] ex_rt_data,
    output logic [RW-1:0] ex_rd,
    output logic          ex_regwrite,
    output logic          ex_memread,
    output logic          ex_memwrite,
    output logic          ex_branch,
    output logic          ex_illegal
);

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLL = 3'd4,
        ALU_SRL = 3'd5,
        ALU_SLT = 3'd6
    } alu_op_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    // Instruction fields
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [15:0] imm;

    assign opcode = id_instr[31:26];
    assign funct  = id_instr[5:0];
    assign imm    = id_instr[15:0];

    logic [DW-1:0] imm_sext;
    logic [DW-1:0] imm_zext;
    logic [DW-1:0] shamt_zext;

    assign imm_sext   = {{(DW-16){imm[15]}}, imm};
    assign imm_zext   = {{(DW-16){1'b0}}, imm};
    assign shamt_zext = {{(DW-5){1'b0}}, id_instr[10:6]};

    // Decoded (combinational) view of the ID-side instruction
    alu_op_e       dec_aluop;
    logic [DW-1:0] dec_in1;
    logic [DW-1:0] dec_in2;
    logic [DW-1:0] dec_rt_data;
    logic [RW-1:0] dec_rd;
    logic          dec_regwrite;
    logic          dec_memread;
    logic          dec_memwrite;
    logic          dec_branch;
    logic          dec_illegal;

    // NOTE: every signal gets a default at the top of the block so that no
    // path through the case statements leaves it unassigned (no latches).
    always_comb begin
        dec_aluop    = ALU_ADD;
        dec_in1      = id_rs_data;
        dec_in2      = id_rt_data;
        dec_rt_data  = id_rt_data;
        dec_rd       = '0;
        dec_regwrite = 1'b0;
        dec_memread  = 1'b0;
        dec_memwrite = 1'b0;
        dec_branch   = 1'b0;
        dec_illegal  = 1'b0;

        case (opcode)
            OP_RTYPE: begin
                dec_rd       = RW'(id_instr[15:11]);
                dec_regwrite = 1'b1;
                case (funct)
                    FN_ADD: dec_aluop = ALU_ADD;
                    FN_SUB: dec_aluop = ALU_SUB;
                    FN_AND: dec_aluop = ALU_AND;
                    FN_OR:  dec_aluop = ALU_OR;
                    FN_SLT: dec_aluop = ALU_SLT;
                    // Shifts operate on rt by the literal shamt field
                    FN_SLL: begin
                        dec_aluop = ALU_SLL;
                        dec_in1   = id_rt_data;
                        dec_in2   = shamt_zext;
                    end
                    FN_SRL: begin
                        dec_aluop = ALU_SRL;
                        dec_in1   = id_rt_data;
                        dec_in2   = shamt_zext;
                    end
                    default: dec_illegal = 1'b1;
                endcase
            end
            OP_ADDI: begin
                dec_rd       = RW'(id_instr[20:16]);
                dec_regwrite = 1'b1;
                dec_in2      = imm_sext;
            end
            OP_SLTI: begin
                dec_rd       = RW'(id_instr[20:16]);
                dec_regwrite = 1'b1;
                dec_aluop    = ALU_SLT;
                dec_in2      = imm_sext;
            end
            OP_ANDI: begin
                dec_rd       = RW'(id_instr[20:16]);
                dec_regwrite = 1'b1;
                dec_aluop    = ALU_AND;
                dec_in2      = imm_zext;
            end
            OP_ORI: begin
                dec_rd       = RW'(id_instr[20:16]);
                dec_regwrite = 1'b1;
                dec_aluop    = ALU_OR;
                dec_in2      = imm_zext;
            end
            OP_LW: begin
                dec_rd       = RW'(id_instr[20:16]);
                dec_regwrite = 1'b1;
                dec_memread  = 1'b1;
                dec_in2      = imm_sext;
            end
            // sw and beq write no register, so rd stays 0
            OP_SW: begin
                dec_memwrite = 1'b1;
                dec_in2      = imm_sext;
            end
            OP_BEQ: begin
                dec_aluop  = ALU_SUB;
                dec_branch = 1'b1;
            end
            default: dec_illegal = 1'b1;
        endcase

        // An illegal instruction issues as a clean marker with every other
        // field zero, so nothing downstream can act on garbage.
        if (dec_illegal) begin
            dec_aluop    = ALU_ADD;
            dec_in1      = '0;
            dec_in2      = '0;
            dec_rt_data  = '0;
            dec_rd       = '0;
            dec_regwrite = 1'b0;
            dec_memread  = 1'b0;
            dec_memwrite = 1'b0;
            dec_branch   = 1'b0;
        end

        // $0 is hard-wired, a write to it is suppressed
        if (dec_rd == '0) begin
            dec_regwrite = 1'b0;
        end
    end

    // Load-use interlock
    logic stall;

`ifdef ALU_ISSUE_HAZARD_EN
    logic [RW-1:0] src_rs;
    logic [RW-1:0] src_rt;
    logic          rt_is_src;

    assign src_rs    = RW'(id_instr[25:21]);
    assign src_rt    = RW'(id_instr[20:16]);
    assign rt_is_src = (opcode == OP_RTYPE) || (opcode == OP_SW) || (opcode == OP_BEQ);

    // A lw in EX has not produced its data yet; hold any reader of its rd.
    assign stall = id_valid && ex_valid && ex_memread && (ex_rd != '0) &&
                   ((ex_rd == src_rs) || (rt_is_src && (ex_rd == src_rt)));
`else
    assign stall = 1'b0;
`endif

    assign id_ready = !stall && (ex_ready || !ex_valid);

    logic transfer;
    assign transfer = id_valid && id_ready;

    // ID/EX register. Priority: reset, flush, transfer, consume.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid    <= 1'b0;
            ex_aluop    <= '0;
            ex_in1      <= '0;
            ex_in2      <= '0;
            ex_rt_data  <= '0;
            ex_rd       <= '0;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
            ex_memwrite <= 1'b0;
            ex_branch   <= 1'b0;
            ex_illegal  <= 1'b0;
        end else if (flush) begin
            // Dropping the entry only needs the valid bit; fields are don't-care
            ex_valid <= 1'b0;
        end else if (transfer) begin
            ex_valid    <= 1'b1;
            ex_aluop    <= dec_aluop;
            ex_in1      <= dec_in1;
            ex_in2      <= dec_in2;
            ex_rt_data  <= dec_rt_data;
            ex_rd       <= dec_rd;
            ex_regwrite <= dec_regwrite;
            ex_memread  <= dec_memread;
            ex_memwrite <= dec_memwrite;
            ex_branch   <= dec_branch;
            ex_illegal  <= dec_illegal;
        end else if (ex_valid && ex_ready) begin
            ex_valid <= 1'b0;
        end
    end

endmodule
